// File: rtl/fir_vis_pkg.sv
// Shared definitions for the audio visualiser: meter FSM states and the
// bar-level ceiling that the VGA bar renderer also relies on.
package fir_vis_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ABS,
        S_SCAN,
        S_UPDATE
    } state_e;

    function automatic int level_max(input int level_w);
        return (1 << level_w) - 1;
    endfunction

    localparam int LEVEL_W_DEF = 6;
    localparam int LEVEL_MAX   = level_max(LEVEL_W_DEF);

endpackage

// File: rtl/fir_level_meter_peak_hold_decay.sv
// Peak tracker: holds the highest level for HOLD_CYCLES, then decays it by 1
// every DECAY_CYCLES until 0.
// Ports: clk, resetn (async, active-low), level/raise (candidate level and
// strobe), clear (sync zero), peak_level (held/decaying peak).
module peak_hold_decay #(
    parameter int LEVEL_W      = 6,
    parameter int HOLD_CYCLES  = 25000,
    parameter int DECAY_CYCLES = 2500
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [LEVEL_W-1:0] level,
    input  logic               raise,
    input  logic               clear,
    output logic [LEVEL_W-1:0] peak_level
);

    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int DECAY_W = $clog2(DECAY_CYCLES + 1);

    logic [LEVEL_W-1:0] peak_q, peak_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [DECAY_W-1:0] decay_q, decay_d;
    logic               tick;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            peak_q  <= '0;
            hold_q  <= '0;
            decay_q <= '0;
        end else begin
            peak_q  <= peak_d;
            hold_q  <= hold_d;
            decay_q <= decay_d;
        end
    end

    always_comb begin
        peak_d  = peak_q;
        hold_d  = hold_q;
        decay_d = decay_q;
        tick    = 1'b0;

        // Hold phase first; the decay divider only runs once hold expires.
        if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end else if (decay_q == DECAY_W'(DECAY_CYCLES - 1)) begin
            decay_d = '0;
            tick    = 1'b1;
        end else begin
            decay_d = decay_q + DECAY_W'(1);
        end

        if (tick && (peak_q != '0)) begin
            peak_d = peak_q - LEVEL_W'(1);
        end

        // A raise overrides a coincident decay tick.
        if (raise && (level >= peak_q)) begin
            peak_d  = level;
            hold_d  = HOLD_W'(HOLD_CYCLES);
            decay_d = '0;
        end

        if (clear) begin
            peak_d  = '0;
            hold_d  = '0;
            decay_d = '0;
        end
    end

    assign peak_level = peak_q;

endmodule

// File: rtl/fir_level_meter.sv
// Level meter behind the FIR stage: |x| -> log2 bar level (MSB index + 1),
// plus a held/decaying peak for the VGA bar renderer.
// Ports: clk, resetn, in_valid/in_data/in_ready (word input), clear,
// inst_level, peak_level, level_valid (1-cycle update pulse).
module fir_level_meter
    import fir_vis_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int LEVEL_W      = 6,
    parameter int HOLD_CYCLES  = 25000,
    parameter int DECAY_CYCLES = 2500
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    input  logic               clear,
    output logic [LEVEL_W-1:0] inst_level,
    output logic [LEVEL_W-1:0] peak_level,
    output logic               level_valid
);

    localparam int LZ_W    = $clog2(DATA_W) + 1;
    localparam int LVL_MAX = level_max(LEVEL_W);

    state_e state_q, state_d;

    logic [DATA_W-1:0]  data_q, data_d;
    logic [DATA_W-1:0]  mag_q, mag_d;
    logic [LZ_W-1:0]    lz_q, lz_d;
    logic [LEVEL_W-1:0] inst_q, inst_d;
    logic               valid_q, valid_d;

    logic               scan_done;
    logic               raise;
    int                 lvl_bits;
    logic [LEVEL_W-1:0] lvl;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            mag_q   <= '0;
            lz_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mag_q   <= mag_d;
            lz_q    <= lz_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    // Normalisation stops once the leading one reaches the MSB.
    assign scan_done = (mag_q == '0) || mag_q[DATA_W-1];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (in_valid) state_d = S_ABS;
            S_ABS:    state_d = S_SCAN;
            S_SCAN:   if (scan_done) state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Level = bit length of the magnitude, clamped to the bar range.
    always_comb begin
        lvl_bits = DATA_W - int'(lz_q);
        if (mag_q == '0) begin
            lvl = '0;
        end else if (lvl_bits > LVL_MAX) begin
            lvl = LEVEL_W'(LVL_MAX);
        end else begin
            lvl = LEVEL_W'(lvl_bits);
        end
    end

    // Datapath / outputs
    always_comb begin
        data_d  = data_q;
        mag_d   = mag_q;
        lz_d    = lz_q;
        inst_d  = inst_q;
        valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) data_d = in_data;
            end
            S_ABS: begin
                // Unsigned negate: the most negative word maps to 2**(DATA_W-1).
                mag_d = data_q[DATA_W-1] ? -data_q : data_q;
                lz_d  = '0;
            end
            S_SCAN: begin
                if (!scan_done) begin
                    mag_d = mag_q << 1;
                    lz_d  = lz_q + LZ_W'(1);
                end
            end
            S_UPDATE: begin
                inst_d  = lvl;
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign raise       = (state_q == S_UPDATE);
    assign in_ready    = (state_q == S_IDLE);
    assign inst_level  = inst_q;
    assign level_valid = valid_q;

    peak_hold_decay #(
        .LEVEL_W     (LEVEL_W),
        .HOLD_CYCLES (HOLD_CYCLES),
        .DECAY_CYCLES(DECAY_CYCLES)
    ) u_peak (
        .clk       (clk),
        .resetn    (resetn),
        .level     (lvl),
        .raise     (raise),
        .clear     (clear),
        .peak_level(peak_level)
    );

endmodule
